evo_csr_byte_bridge: RTL and testbench
======================================

Name: evo_csr_byte_bridge

Overview:
- Upstream master stage for the EVO CSR slaves, including the XB info register.
- Converts a framed byte stream from the I2C slave byte engine into single 32-bit Avalon-MM CSR write or read transactions.
- Returns read data to the byte engine as 4 bytes, LSB first.
- Handles slave waitrequest stalls and a readdatavalid timeout.

Parameters:
- CSR_AWIDTH, 7, CSR address width in bits; legal range 1..7; carried in cmd byte bits [CSR_AWIDTH-1:0].
- CSR_DWIDTH, 32, CSR data width; fixed at 32; any other value is unsupported.
- RD_TIMEOUT, 16, maximum cycles to wait in RD_WAIT for readdatavalid; legal range 1..255.
- TIMEOUT_VAL, 32'hFFFF_FFFF, readback value substituted on timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- frm_start  in  1  single-cycle pulse; start of new frame (I2C START/RESTART)
- rx_valid  in  1  rx_data valid this cycle; no backpressure
- rx_data  in  8  received byte
- tx_valid  out  1  tx_data valid
- tx_data  out  8  byte to transmit
- tx_ready  in  1  byte engine accepts tx_data this cycle
- avs_csr_address  out  CSR_AWIDTH  CSR address
- avs_csr_write  out  1  write request
- avs_csr_writedata  out  32  write data
- avs_csr_read  out  1  read request
- avs_csr_waitrequest  in  1  slave stall
- avs_csr_readdatavalid  in  1  read data valid
- avs_csr_readdata  in  32  read data
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  one-cycle pulse when a read times out

Behaviour:
- Reset values:
  - state = IDLE; tx_valid = 0; tx_data = 0.
  - avs_csr_write = 0; avs_csr_read = 0; avs_csr_address = 0; avs_csr_writedata = 0.
  - busy = 0; err_timeout = 0; byte counter = 0; timeout counter = 0.
- All outputs are registered.
- Reset may assert in any state. It aborts any bus request immediately (write/read drop asynchronously). No bus access completes after reset.
- Cmd byte format:
  - bit7 = 1 for write, 0 for read.
  - bits[CSR_AWIDTH-1:0] = address.
  - Remaining bits are ignored.
- States:
  - IDLE:
    - frm_start goes to CMD.
    - rx_valid is ignored.
  - CMD:
    - rx_valid latches the address.
    - bit7 = 1 goes to WDATA with byte counter = 0.
    - bit7 = 0 goes to RD_BUS.
  - WDATA:
    - Each rx_valid byte is shifted into writedata at byte lane [8*cnt+7:8*cnt], LSB first, and cnt is incremented.
    - On the 4th byte (cnt = 3), go to WR_BUS.
  - WR_BUS:
    - avs_csr_write is asserted the cycle after the 4th byte is accepted.
    - Address and writedata are held stable while waitrequest = 1.
    - The request is accepted on the first cycle with waitrequest = 0.
    - write deasserts the next cycle; go to IDLE.
  - RD_BUS:
    - avs_csr_read is asserted the cycle after the cmd byte.
    - It is held while waitrequest = 1. On acceptance, read deasserts the next cycle; go to RD_WAIT with timeout counter = 0.
  - RD_WAIT:
    - avs_csr_readdatavalid = 1 latches readdata into the tx buffer; go to TX.
    - Otherwise the counter increments. When the counter reaches RD_TIMEOUT-1 without valid:
      - load TIMEOUT_VAL into the tx buffer;
      - pulse err_timeout;
      - go to TX.
    - If valid and timeout coincide, valid wins and there is no error pulse.
    - readdatavalid is ignored in every state except RD_WAIT; slaves may assert it on non-read cycles.
  - TX:
    - tx_valid = 1 and tx_data = buffer byte[cnt].
    - On tx_valid && tx_ready, cnt is incremented and the next byte is presented the following cycle.
    - After byte 3 is accepted: tx_valid = 0, go to IDLE.
- frm_start handling:
  - In CMD, WDATA or TX: abort the current frame, reset cnt, go to CMD. tx_valid drops the next cycle. A partial write is never issued.
  - In WR_BUS, RD_BUS or RD_WAIT: ignored. The bus access always completes.
- rx_valid is ignored outside CMD and WDATA.
- frm_start and rx_valid in the same cycle: frm_start takes effect and the byte is discarded.
- There is no stop input. A frame that never completes stays in CMD or WDATA until the next frm_start or reset.

Test Plan:
- Write: frm_start; bytes 0x80, 0x03, 0x00, 0x00, 0x00 -> one avs_csr_write cycle, address = 0, writedata = 32'h0000_0003, asserted 1 cycle after the 5th byte; busy returns to 0.
- Read with registered slave (readdatavalid 1 cycle after accept, readdata = "ALO " = 32'h414C_4F20); frm_start; byte 0x00 -> avs_csr_read for 1 cycle; tx bytes 0x20, 0x4F, 0x4C, 0x41 in order; no err_timeout.
- Waitrequest stall: waitrequest = 1 for 5 cycles during a write of 32'hDEAD_BEEF to address 0x05 -> write held 6 cycles with address and data stable; exactly one acceptance.
- Timeout: read with readdatavalid never asserted, RD_TIMEOUT = 16 -> err_timeout pulses exactly once 16 cycles after read acceptance; tx bytes 0xFF x4.
- Abort: frm_start after 2 write data bytes, then a complete read frame -> no avs_csr_write ever; the read completes normally.
- TX backpressure: tx_ready low for 3 cycles before each byte, and readdatavalid pulsed while in TX -> tx_data stable while stalled; the 4 bytes are correct; the spurious valid is ignored.

Source files
------------

// File: rtl/evo_csr_byte_bridge.sv
// Byte-stream to Avalon-MM CSR master: turns framed I2C bytes into single 32-bit
// CSR writes or reads and streams read data back LSB first.
module evo_csr_byte_bridge #(
    parameter int          CSR_AWIDTH  = 7,
    parameter int          CSR_DWIDTH  = 32,
    parameter int          RD_TIMEOUT  = 16,
    parameter logic [31:0] TIMEOUT_VAL = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  frm_start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic [CSR_AWIDTH-1:0] avs_csr_address,
    output logic                  avs_csr_write,
    output logic [CSR_DWIDTH-1:0] avs_csr_writedata,
    output logic                  avs_csr_read,
    input  logic                  avs_csr_waitrequest,
    input  logic                  avs_csr_readdatavalid,
    input  logic [CSR_DWIDTH-1:0] avs_csr_readdata,
    output logic                  busy,
    output logic                  err_timeout
);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, WR_BUS, RD_BUS, RD_WAIT, TX} state_t;

    localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

    state_t                  state, state_d;
    logic [1:0]              cnt, cnt_d, cnt_inc;
    logic [7:0]              tcnt, tcnt_d;
    logic [CSR_DWIDTH-1:0]   txbuf, txbuf_d;
    logic                    tx_valid_d, write_d, read_d, busy_d, err_d;
    logic [7:0]              tx_data_d;
    logic [CSR_AWIDTH-1:0]   addr_d;
    logic [CSR_DWIDTH-1:0]   wdata_d;
    logic                    unused_rx_bits;

    assign unused_rx_bits = ^rx_data;
    assign cnt_inc        = cnt + 2'd1;

    // Async reset drops any pending bus request immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= IDLE;
            cnt               <= 2'd0;
            tcnt              <= 8'd0;
            txbuf             <= '0;
            tx_valid          <= 1'b0;
            tx_data           <= 8'd0;
            avs_csr_address   <= '0;
            avs_csr_writedata <= '0;
            avs_csr_write     <= 1'b0;
            avs_csr_read      <= 1'b0;
            busy              <= 1'b0;
            err_timeout       <= 1'b0;
        end else begin
            state             <= state_d;
            cnt               <= cnt_d;
            tcnt              <= tcnt_d;
            txbuf             <= txbuf_d;
            tx_valid          <= tx_valid_d;
            tx_data           <= tx_data_d;
            avs_csr_address   <= addr_d;
            avs_csr_writedata <= wdata_d;
            avs_csr_write     <= write_d;
            avs_csr_read      <= read_d;
            busy              <= busy_d;
            err_timeout       <= err_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        tcnt_d     = tcnt;
        txbuf_d    = txbuf;
        tx_valid_d = tx_valid;
        tx_data_d  = tx_data;
        addr_d     = avs_csr_address;
        wdata_d    = avs_csr_writedata;
        write_d    = avs_csr_write;
        read_d     = avs_csr_read;
        err_d      = 1'b0;

        case (state)
            IDLE: begin
                if (frm_start) begin
                    state_d = CMD;
                    cnt_d   = 2'd0;
                end
            end
            CMD: begin
                if (frm_start) begin
                    cnt_d = 2'd0;
                end else if (rx_valid) begin
                    addr_d = rx_data[CSR_AWIDTH-1:0];
                    cnt_d  = 2'd0;
                    if (rx_data[7]) begin
                        state_d = WDATA;
                    end else begin
                        state_d = RD_BUS;
                        read_d  = 1'b1;
                    end
                end
            end
            WDATA: begin
                // A restart mid-write discards the partial word; nothing is issued.
                if (frm_start) begin
                    state_d = CMD;
                    cnt_d   = 2'd0;
                end else if (rx_valid) begin
                    wdata_d[{cnt, 3'b000} +: 8] = rx_data;
                    cnt_d = cnt_inc;
                    if (cnt == 2'd3) begin
                        state_d = WR_BUS;
                        write_d = 1'b1;
                    end
                end
            end
            WR_BUS: begin
                if (!avs_csr_waitrequest) begin
                    write_d = 1'b0;
                    state_d = IDLE;
                end
            end
            RD_BUS: begin
                if (!avs_csr_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = RD_WAIT;
                    tcnt_d  = 8'd0;
                end
            end
            RD_WAIT: begin
                // Valid data wins over a coinciding timeout.
                if (avs_csr_readdatavalid) begin
                    txbuf_d    = avs_csr_readdata;
                    tx_data_d  = avs_csr_readdata[7:0];
                    tx_valid_d = 1'b1;
                    cnt_d      = 2'd0;
                    state_d    = TX;
                end else if (tcnt == TO_LAST) begin
                    txbuf_d    = TIMEOUT_VAL;
                    tx_data_d  = TIMEOUT_VAL[7:0];
                    tx_valid_d = 1'b1;
                    cnt_d      = 2'd0;
                    err_d      = 1'b1;
                    state_d    = TX;
                end else begin
                    tcnt_d = tcnt + 8'd1;
                end
            end
            TX: begin
                if (frm_start) begin
                    tx_valid_d = 1'b0;
                    cnt_d      = 2'd0;
                    state_d    = CMD;
                end else if (tx_valid && tx_ready) begin
                    if (cnt == 2'd3) begin
                        tx_valid_d = 1'b0;
                        cnt_d      = 2'd0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d     = cnt_inc;
                        tx_data_d = txbuf[{cnt_inc, 3'b000} +: 8];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_evo_csr_byte_bridge.sv
// Directed self-checking bench for evo_csr_byte_bridge: writes, reads, stalls,
// read timeout, frame abort, tx backpressure and reset during a bus request.
module tb_evo_csr_byte_bridge;

    logic        clk;
    logic        rstn;
    logic        frm_start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [6:0]  avs_csr_address;
    logic        avs_csr_write;
    logic [31:0] avs_csr_writedata;
    logic        avs_csr_read;
    logic        avs_csr_waitrequest;
    logic        avs_csr_readdatavalid;
    logic [31:0] avs_csr_readdata;
    logic        busy;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;
    int wr_acc = 0, wr_hi = 0, rd_acc = 0, rd_hi = 0, err_cnt = 0;

    evo_csr_byte_bridge dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .frm_start             (frm_start),
        .rx_valid              (rx_valid),
        .rx_data               (rx_data),
        .tx_valid              (tx_valid),
        .tx_data               (tx_data),
        .tx_ready              (tx_ready),
        .avs_csr_address       (avs_csr_address),
        .avs_csr_write         (avs_csr_write),
        .avs_csr_writedata     (avs_csr_writedata),
        .avs_csr_read          (avs_csr_read),
        .avs_csr_waitrequest   (avs_csr_waitrequest),
        .avs_csr_readdatavalid (avs_csr_readdatavalid),
        .avs_csr_readdata      (avs_csr_readdata),
        .busy                  (busy),
        .err_timeout           (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus activity tallies, sampled mid-cycle where inputs and outputs are settled.
    always @(negedge clk) begin
        if (avs_csr_write) wr_hi++;
        if (avs_csr_write && !avs_csr_waitrequest) wr_acc++;
        if (avs_csr_read) rd_hi++;
        if (avs_csr_read && !avs_csr_waitrequest) rd_acc++;
        if (err_timeout) err_cnt++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame();
        frm_start = 1'b1;
        cycle();
        frm_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        cycle();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic expect_tx_word(input logic [31:0] word, input string name);
        int n;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!tx_valid && n < 20) begin
                cycle();
                n++;
            end
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== word[8*i +: 8]) begin
                errors++;
                $display("[TB] FAIL %s byte%0d: got valid=%b data=%h expected valid=1 data=%h",
                         name, i, tx_valid, tx_data, word[8*i +: 8]);
            end
            cycle();
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        cycle();
        cycle();
        checks++;
        if ({tx_valid, tx_data, avs_csr_write, avs_csr_read, busy, err_timeout} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got txv=%b txd=%h wr=%b rd=%b busy=%b err=%b expected all 0",
                     tx_valid, tx_data, avs_csr_write, avs_csr_read, busy, err_timeout);
        end
        checks++;
        if (avs_csr_address !== 7'd0 || avs_csr_writedata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_bus: got addr=%h wdata=%h expected 0 0", avs_csr_address, avs_csr_writedata);
        end
        rstn = 1'b1;
        cycle();
        // Junk readdatavalid while idle must not start anything.
        avs_csr_readdatavalid = 1'b1;
        avs_csr_readdata      = 32'h1234_5678;
        cycle();
        avs_csr_readdatavalid = 1'b0;
        cycle();
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_spurious_rdv: got busy=%b txv=%b expected 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_write();
        int w0 = wr_acc;
        int h0 = wr_hi;
        avs_csr_waitrequest = 1'b0;
        start_frame();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_busy: got %b expected 1", busy);
        end
        send_byte(8'h80);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if (avs_csr_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_early: got %b expected 0", avs_csr_write);
        end
        send_byte(8'h00);
        checks++;
        if (avs_csr_write !== 1'b1 || avs_csr_address !== 7'h00 || avs_csr_writedata !== 32'h0000_0003) begin
            errors++;
            $display("[TB] FAIL write_issue: got wr=%b addr=%h data=%h expected 1 00 00000003",
                     avs_csr_write, avs_csr_address, avs_csr_writedata);
        end
        cycle();
        checks++;
        if (avs_csr_write !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_done: got wr=%b busy=%b expected 0 0", avs_csr_write, busy);
        end
        checks++;
        if (wr_acc - w0 !== 1 || wr_hi - h0 !== 1) begin
            errors++;
            $display("[TB] FAIL write_count: got acc=%0d high=%0d expected 1 1", wr_acc - w0, wr_hi - h0);
        end
    endtask

    task automatic test_read();
        int r0 = rd_acc;
        int h0 = rd_hi;
        int e0 = err_cnt;
        start_frame();
        send_byte(8'h00);
        checks++;
        if (avs_csr_read !== 1'b1 || avs_csr_address !== 7'h00) begin
            errors++;
            $display("[TB] FAIL read_issue: got rd=%b addr=%h expected 1 00", avs_csr_read, avs_csr_address);
        end
        cycle();
        checks++;
        if (avs_csr_read !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_drop: got %b expected 0", avs_csr_read);
        end
        avs_csr_readdatavalid = 1'b1;
        avs_csr_readdata      = 32'h414C_4F20;
        cycle();
        avs_csr_readdatavalid = 1'b0;
        avs_csr_readdata      = 32'h0;
        expect_tx_word(32'h414C_4F20, "read");
        checks++;
        if (rd_acc - r0 !== 1 || rd_hi - h0 !== 1 || err_cnt - e0 !== 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_summary: got acc=%0d high=%0d err=%0d busy=%b expected 1 1 0 0",
                     rd_acc - r0, rd_hi - h0, err_cnt - e0, busy);
        end
    endtask

    task automatic test_wait_stall();
        int w0 = wr_acc;
        int h0 = wr_hi;
        start_frame();
        send_byte(8'h85);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        avs_csr_waitrequest = 1'b1;
        send_byte(8'hDE);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (avs_csr_write !== 1'b1 || avs_csr_address !== 7'h05 || avs_csr_writedata !== 32'hDEAD_BEEF) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got wr=%b addr=%h data=%h expected 1 05 deadbeef",
                         k, avs_csr_write, avs_csr_address, avs_csr_writedata);
            end
            cycle();
        end
        avs_csr_waitrequest = 1'b0;
        cycle();
        checks++;
        if (avs_csr_write !== 1'b0 || wr_acc - w0 !== 1 || wr_hi - h0 !== 6) begin
            errors++;
            $display("[TB] FAIL stall_count: got wr=%b acc=%0d high=%0d expected 0 1 6",
                     avs_csr_write, wr_acc - w0, wr_hi - h0);
        end
    endtask

    task automatic test_timeout();
        int e0 = err_cnt;
        int n  = 0;
        start_frame();
        send_byte(8'h05);
        cycle();
        // n counts cycles from the first RD_WAIT cycle to the one showing err_timeout.
        while (!err_timeout && n < 40) begin
            cycle();
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got %0d expected 16", n);
        end
        expect_tx_word(32'hFFFF_FFFF, "timeout");
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("[TB] FAIL timeout_pulses: got %0d expected 1", err_cnt - e0);
        end
    endtask

    task automatic test_abort();
        int w0 = wr_acc;
        int h0 = wr_hi;
        start_frame();
        send_byte(8'h81);
        send_byte(8'h11);
        send_byte(8'h22);
        start_frame();
        checks++;
        if (busy !== 1'b1 || avs_csr_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_state: got busy=%b wr=%b expected 1 0", busy, avs_csr_write);
        end
        send_byte(8'h02);
        checks++;
        if (avs_csr_read !== 1'b1 || avs_csr_address !== 7'h02) begin
            errors++;
            $display("[TB] FAIL abort_read: got rd=%b addr=%h expected 1 02", avs_csr_read, avs_csr_address);
        end
        cycle();
        avs_csr_readdatavalid = 1'b1;
        avs_csr_readdata      = 32'h1234_5678;
        cycle();
        avs_csr_readdatavalid = 1'b0;
        avs_csr_readdata      = 32'h0;
        expect_tx_word(32'h1234_5678, "abort_rd");
        checks++;
        if (wr_acc - w0 !== 0 || wr_hi - h0 !== 0) begin
            errors++;
            $display("[TB] FAIL abort_nowrite: got acc=%0d high=%0d expected 0 0", wr_acc - w0, wr_hi - h0);
        end
    endtask

    task automatic test_tx_backpressure();
        logic [31:0] word = 32'h8899_AABB;
        int e0 = err_cnt;
        start_frame();
        send_byte(8'h07);
        cycle();
        avs_csr_readdatavalid = 1'b1;
        avs_csr_readdata      = word;
        cycle();
        avs_csr_readdatavalid = 1'b0;
        avs_csr_readdata      = 32'h0;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== word[8*i +: 8]) begin
                    errors++;
                    $display("[TB] FAIL bp_stall%0d_%0d: got valid=%b data=%h expected 1 %h",
                             i, k, tx_valid, tx_data, word[8*i +: 8]);
                end
                avs_csr_readdatavalid = (k == 0);
                avs_csr_readdata      = 32'h5555_5555;
                cycle();
                avs_csr_readdatavalid = 1'b0;
            end
            tx_ready = 1'b1;
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== word[8*i +: 8]) begin
                errors++;
                $display("[TB] FAIL bp_accept%0d: got valid=%b data=%h expected 1 %h",
                         i, tx_valid, tx_data, word[8*i +: 8]);
            end
            cycle();
            tx_ready = 1'b0;
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || err_cnt - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL bp_end: got txv=%b busy=%b err=%0d expected 0 0 0", tx_valid, busy, err_cnt - e0);
        end
    endtask

    task automatic test_reset_abort();
        int w0 = wr_acc;
        start_frame();
        send_byte(8'h83);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        avs_csr_waitrequest = 1'b1;
        send_byte(8'h04);
        cycle();
        rstn = 1'b0;
        #1;
        checks++;
        if (avs_csr_write !== 1'b0 || busy !== 1'b0 || avs_csr_address !== 7'h00) begin
            errors++;
            $display("[TB] FAIL reset_abort: got wr=%b busy=%b addr=%h expected 0 0 00",
                     avs_csr_write, busy, avs_csr_address);
        end
        avs_csr_waitrequest = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
        cycle();
        cycle();
        checks++;
        if (wr_acc - w0 !== 0 || avs_csr_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_noaccept: got acc=%0d wr=%b expected 0 0", wr_acc - w0, avs_csr_write);
        end
    endtask

    initial begin
        rstn                  = 1'b0;
        frm_start             = 1'b0;
        rx_valid              = 1'b0;
        rx_data               = 8'h00;
        tx_ready              = 1'b0;
        avs_csr_waitrequest   = 1'b0;
        avs_csr_readdatavalid = 1'b0;
        avs_csr_readdata      = 32'h0;
        $display("[TB] starting evo_csr_byte_bridge bench");
        test_reset();
        test_write();
        test_read();
        test_wait_stall();
        test_timeout();
        test_abort();
        test_tx_backpressure();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
